sad_search_scheduler: RTL and testbench
=======================================

SAD_SEARCH_SCHEDULER -- requirements
Module: sad_search_scheduler

Interface
REQ-001 Parameter POS_W, default 4: bits per candidate axis; the grid is 2^POS_W x 2^POS_W candidates.
REQ-002 Parameter SAD_W, default 32: SAD value width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  start-search request, sampled only in IDLE.
REQ-006 busy  output  1  high while a search is in progress (any state other than IDLE).
REQ-007 done  output  1  one-cycle pulse when a search completes.
REQ-008 sad_go  output  1  one-cycle start pulse to the SAD datapath.
REQ-009 sad_done  input  1  SAD datapath completion; honoured only in WAIT.
REQ-010 sad_value  input  SAD_W  SAD result, valid in the cycle sad_done is high.
REQ-011 cand_x, cand_y  output  POS_W each  current candidate offset driven to the datapath.
REQ-012 best_sad  output  SAD_W  minimum SAD found so far.
REQ-013 best_x, best_y  output  POS_W each  offset of best_sad.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT, CMP and DONE, encoded in 3 bits.
REQ-015 IDLE: go=1 -> ISSUE; cand_x, cand_y cleared to 0; best_sad set to all ones; best_x, best_y cleared to 0.
REQ-016 ISSUE: sad_go=1 for exactly one cycle -> WAIT.
REQ-017 WAIT: hold until sad_done=1; then capture sad_value into an internal register -> CMP.
REQ-018 CMP: if captured < best_sad (strict, unsigned), update best_sad/best_x/best_y from captured value and cand_x/cand_y. On ties the earliest candidate wins.
REQ-019 CMP candidate advance: if cand_x != max, increment cand_x -> ISSUE. Else if cand_y != max, set cand_x=0, increment cand_y -> ISSUE. Else -> DONE.
REQ-020 Scan order: raster, x fastest.
REQ-021 cand_x and cand_y SHALL be stable from ISSUE through CMP of each candidate.
REQ-022 DONE: done=1 for one cycle -> IDLE; best_* outputs hold until the next go is accepted.
REQ-023 go while busy=1 SHALL be ignored; sad_done outside WAIT SHALL be ignored.
REQ-024 sad_done in the same cycle as sad_go SHALL NOT be sampled; the minimum per-candidate period is 3 cycles (ISSUE, WAIT, CMP).
REQ-025 Full-search latency with sad_done returned one cycle after sad_go: 1 + 3*2^(2*POS_W) cycles from go to done.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, with busy=0, done=0, sad_go=0, cand_x=cand_y=0, best_sad=all ones, best_x=best_y=0.
REQ-027 Reset mid-search SHALL abandon the search with no done pulse; the first go after reset release starts a fresh search.

Configuration
REQ-028 Macro SAD_SCHED_EARLY_TERM_EN: when defined, CMP with captured value == 0 SHALL update best_* and go directly to DONE, skipping the remaining candidates.
REQ-029 When SAD_SCHED_EARLY_TERM_EN is not defined, every candidate is always visited, regardless of the captured value.

Verification
REQ-030 Basic search: POS_W=2, datapath returns SAD = 100 - 4*y - x, except (2,1) which returns 5 -> best_sad=5, best_x=2, best_y=1; done after 16 sad_go pulses.
REQ-031 Tie: POS_W=2, SAD=7 at (1,0) and at (3,2), 50 elsewhere -> best=(1,0), best_sad=7.
REQ-032 Protocol: go held high through the whole search; stray sad_done in ISSUE and CMP; sad_done delayed 10 cycles -> exactly 16 sad_go pulses, exactly one done, result unchanged.
REQ-033 Reset: rst low during WAIT of candidate 5 -> all outputs at reset values, no done; a subsequent go completes a normal search.
REQ-034 Early termination: with macro defined, SAD=0 at (1,0) -> done after 2 sad_go pulses, best_sad=0. With macro undefined -> 16 pulses, same best_sad and position.
REQ-035 All-max: every SAD = all ones -> best_sad=all ones, best=(0,0), since there is no strict improvement.

Source files
------------

// File: rtl/sad_search_scheduler.sv
// sad_search_scheduler: full-search motion-estimation sequencer.
// Walks every (x,y) candidate of a 2^POS_W x 2^POS_W grid in raster order
// (x fastest). For each candidate it pulses sad_go, waits for sad_done and
// keeps the strictly smallest SAD, so on ties the earliest candidate wins.
// Optional feature macro: SAD_SCHED_EARLY_TERM_EN. When defined, a SAD of
// zero ends the search at once, because no later candidate can beat it.
module sad_search_scheduler #(
    parameter int POS_W = 4,
    parameter int SAD_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             sad_go,
    input  logic             sad_done,
    input  logic [SAD_W-1:0] sad_value,
    output logic [POS_W-1:0] cand_x,
    output logic [POS_W-1:0] cand_y,
    output logic [SAD_W-1:0] best_sad,
    output logic [POS_W-1:0] best_x,
    output logic [POS_W-1:0] best_y
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [POS_W-1:0] POS_MAX = '1;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   cand_x_q, cand_x_d;
    logic [POS_W-1:0]   cand_y_q, cand_y_d;
    logic [SAD_W-1:0]   cap_q, cap_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [POS_W-1:0]   best_x_q, best_x_d;
    logic [POS_W-1:0]   best_y_q, best_y_d;

    // State and datapath registers; reset abandons any search in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            cap_q      <= '0;
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            cap_q      <= cap_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
        end
    end

    // Next-state logic: sequencing, SAD capture, best tracking, raster advance.
    always_comb begin
        state_d    = state_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        cap_d      = cap_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d    = S_ISSUE;
                    cand_x_d   = '0;
                    cand_y_d   = '0;
                    best_sad_d = '1;
                    best_x_d   = '0;
                    best_y_d   = '0;
                end
            end
            S_ISSUE: begin
                // sad_done is deliberately not looked at here.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sad_done) begin
                    cap_d   = sad_value;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                // Strict compare keeps the earliest candidate on ties.
                if (cap_q < best_sad_q) begin
                    best_sad_d = cap_q;
                    best_x_d   = cand_x_q;
                    best_y_d   = cand_y_q;
                end
`ifdef SAD_SCHED_EARLY_TERM_EN
                if (cap_q == '0) begin
                    state_d = S_DONE;
                end else
`endif
                if (cand_x_q != POS_MAX) begin
                    cand_x_d = cand_x_q + 1'b1;
                    state_d  = S_ISSUE;
                end else if (cand_y_q != POS_MAX) begin
                    cand_x_d = '0;
                    cand_y_d = cand_y_q + 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sad_go   = (state_q == S_ISSUE);
    assign cand_x   = cand_x_q;
    assign cand_y   = cand_y_q;
    assign best_sad = best_sad_q;
    assign best_x   = best_x_q;
    assign best_y   = best_y_q;

endmodule

// File: tb/tb_sad_search_scheduler.sv
// Directed testbench for sad_search_scheduler (POS_W=2, 4x4 grid).
// A behavioural SAD datapath answers each sad_go after resp_delay cycles and
// can inject stray sad_done pulses in the ISSUE and CMP cycles.
module tb_sad_search_scheduler;

    localparam int POS_W = 2;
    localparam int SAD_W = 32;
    localparam int NCAND = 16;
    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0;
    logic             busy, done, sad_go;
    logic             sad_done = 1'b0;
    logic [SAD_W-1:0] sad_value = '0;
    logic [POS_W-1:0] cand_x, cand_y, best_x, best_y;
    logic [SAD_W-1:0] best_sad;

    int checks = 0;
    int failures = 0;

    // Datapath model configuration (written only by the test tasks).
    int mode = 0;
    int resp_delay = 1;
    bit stray_en = 1'b0;

    // Counters owned by the monitor / model.
    int pulse_cnt = 0, done_cnt = 0, busy_cycles = 0, seq_idx = 0, order_err_cnt = 0;
    int stab_err_cnt = 0;
    int m_cx = 0, m_cy = 0;

    sad_search_scheduler #(.POS_W(POS_W), .SAD_W(SAD_W)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .sad_go(sad_go),
        .sad_done(sad_done), .sad_value(sad_value), .cand_x(cand_x), .cand_y(cand_y),
        .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
    );

    always #5 clk = ~clk;

    function automatic logic [SAD_W-1:0] sad_for(input int x, input int y);
        logic [SAD_W-1:0] r;
        case (mode)
            0: r = (x == 2 && y == 1) ? 32'd5 : 32'(100 - 4 * y - x);
            1: r = ((x == 1 && y == 0) || (x == 3 && y == 2)) ? 32'd7 : 32'd50;
            2: r = (x == 1 && y == 0) ? 32'd0 : 32'(100 - 4 * y - x);
            default: r = SAD_MAX;
        endcase
        return r;
    endfunction

    // Monitor: counts pulses, done, busy cycles and checks raster order.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cycles++;
        if (busy !== 1'b1) seq_idx = 0;
        if (sad_go === 1'b1) begin
            pulse_cnt++;
            if (int'(cand_x) != seq_idx % 4 || int'(cand_y) != seq_idx / 4) order_err_cnt++;
            seq_idx++;
        end
    end

    // SAD datapath model, also checks candidate stability within a candidate.
    always begin
        @(negedge clk);
        if (sad_go === 1'b1) begin
            m_cx = int'(cand_x);
            m_cy = int'(cand_y);
            if (stray_en) begin
                sad_done  = 1'b1;
                sad_value = '0;
            end else begin
                sad_done = 1'b0;
            end
            for (int i = 1; i < resp_delay; i++) begin
                @(negedge clk);
                sad_done = 1'b0;
                if (busy === 1'b1 && (int'(cand_x) != m_cx || int'(cand_y) != m_cy)) stab_err_cnt++;
            end
            @(negedge clk);
            if (busy === 1'b1 && (int'(cand_x) != m_cx || int'(cand_y) != m_cy)) stab_err_cnt++;
            sad_done  = 1'b1;
            sad_value = sad_for(m_cx, m_cy);
            @(negedge clk);
            if (busy === 1'b1 && (int'(cand_x) != m_cx || int'(cand_y) != m_cy)) stab_err_cnt++;
            sad_done = stray_en;
            if (stray_en) sad_value = '0;
        end else begin
            sad_done = 1'b0;
        end
    end

    // Start a search and wait (bounded) for its done pulse.
    task automatic run_search(input bit hold, output bit to, output int pulses,
                              output int dones, output int bcyc, output int oerr,
                              output int serr);
        int p0, d0, b0, o0, s0;
        @(negedge clk); #1;
        p0 = pulse_cnt; d0 = done_cnt; b0 = busy_cycles; o0 = order_err_cnt; s0 = stab_err_cnt;
        go = 1'b1;
        if (!hold) begin
            @(negedge clk); #1;
            go = 1'b0;
        end
        to = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (done_cnt != d0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk); #1;
        end
        go = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        pulses = pulse_cnt - p0;
        dones  = done_cnt - d0;
        bcyc   = busy_cycles - b0;
        oerr   = order_err_cnt - o0;
        serr   = stab_err_cnt - s0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (sad_go !== 1'b0) begin failures++; $display("FAIL reset_sad_go got=%b want=0", sad_go); end
        checks++; if (best_sad !== SAD_MAX) begin failures++; $display("FAIL reset_best_sad got=%h want=%h", best_sad, SAD_MAX); end
        checks++; if ({cand_x, cand_y, best_x, best_y} !== '0) begin failures++;
            $display("FAIL reset_pos got cx=%0d cy=%0d bx=%0d by=%0d want all 0", cand_x, cand_y, best_x, best_y); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b want=0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        bit to; int p, d, b, o, s;
        mode = 0; resp_delay = 1; stray_en = 1'b0;
        run_search(1'b0, to, p, d, b, o, s);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout want=done"); end
        checks++; if (p != NCAND) begin failures++; $display("FAIL basic_pulses got=%0d want=%0d", p, NCAND); end
        checks++; if (d != 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", d); end
        checks++; if (b != 1 + 3 * NCAND) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", b, 1 + 3 * NCAND); end
        checks++; if (best_sad !== 32'd5) begin failures++; $display("FAIL basic_best_sad got=%0d want=5", best_sad); end
        checks++; if (best_x !== 2'd2 || best_y !== 2'd1) begin failures++;
            $display("FAIL basic_best_pos got=(%0d,%0d) want=(2,1)", best_x, best_y); end
        checks++; if (o != 0) begin failures++; $display("FAIL basic_raster_order got=%0d errors want=0", o); end
        checks++; if (s != 0) begin failures++; $display("FAIL basic_cand_stable got=%0d errors want=0", s); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (best_sad !== 32'd5 || best_x !== 2'd2 || best_y !== 2'd1) begin failures++;
            $display("FAIL basic_hold got=%0d@(%0d,%0d) want=5@(2,1)", best_sad, best_x, best_y); end
        $display("test_basic: best=%0d at (%0d,%0d) pulses=%0d", best_sad, best_x, best_y, p);
    endtask

    task automatic test_tie();
        bit to; int p, d, b, o, s;
        mode = 1; resp_delay = 1; stray_en = 1'b0;
        run_search(1'b0, to, p, d, b, o, s);
        checks++; if (to) begin failures++; $display("FAIL tie_timeout got=timeout want=done"); end
        checks++; if (best_sad !== 32'd7 || best_x !== 2'd1 || best_y !== 2'd0) begin failures++;
            $display("FAIL tie_best got=%0d@(%0d,%0d) want=7@(1,0)", best_sad, best_x, best_y); end
        $display("test_tie: best=%0d at (%0d,%0d)", best_sad, best_x, best_y);
    endtask

    task automatic test_protocol();
        bit to; int p, d, b, o, s;
        mode = 0; resp_delay = 10; stray_en = 1'b1;
        run_search(1'b1, to, p, d, b, o, s);
        stray_en = 1'b0; resp_delay = 1;
        repeat (6) @(negedge clk);
        #1;
        d = d + 0;
        checks++; if (to) begin failures++; $display("FAIL proto_timeout got=timeout want=done"); end
        checks++; if (p != NCAND) begin failures++; $display("FAIL proto_pulses got=%0d want=%0d", p, NCAND); end
        checks++; if (d != 1) begin failures++; $display("FAIL proto_done_count got=%0d want=1", d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL proto_no_restart busy=%b want=0", busy); end
        checks++; if (best_sad !== 32'd5 || best_x !== 2'd2 || best_y !== 2'd1) begin failures++;
            $display("FAIL proto_best got=%0d@(%0d,%0d) want=5@(2,1)", best_sad, best_x, best_y); end
        checks++; if (s != 0) begin failures++; $display("FAIL proto_cand_stable got=%0d errors want=0", s); end
        $display("test_protocol: pulses=%0d dones=%0d best=%0d", p, d, best_sad);
    endtask

    task automatic test_reset_mid();
        bit to, reached; int p, d, b, o, s, d0, p0;
        mode = 0; resp_delay = 3; stray_en = 1'b0;
        @(negedge clk); #1;
        p0 = pulse_cnt; d0 = done_cnt;
        go = 1'b1;
        @(negedge clk); #1;
        go = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (pulse_cnt - p0 == 6) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        checks++; if (!reached) begin failures++; $display("FAIL rstmid_reach got=%0d pulses want=6", pulse_cnt - p0); end
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sad_go !== 1'b0) begin failures++;
            $display("FAIL rstmid_ctrl got busy=%b done=%b sad_go=%b want 0 0 0", busy, done, sad_go); end
        checks++; if (best_sad !== SAD_MAX || {cand_x, cand_y, best_x, best_y} !== '0) begin failures++;
            $display("FAIL rstmid_data got best=%h cx=%0d cy=%0d bx=%0d by=%0d want all ones and zeros",
                     best_sad, cand_x, cand_y, best_x, best_y); end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - d0); end
        resp_delay = 1;
        run_search(1'b0, to, p, d, b, o, s);
        checks++; if (to || p != NCAND || d != 1) begin failures++;
            $display("FAIL rstmid_rerun got to=%0b pulses=%0d dones=%0d want 0 16 1", to, p, d); end
        checks++; if (best_sad !== 32'd5 || best_x !== 2'd2 || best_y !== 2'd1) begin failures++;
            $display("FAIL rstmid_best got=%0d@(%0d,%0d) want=5@(2,1)", best_sad, best_x, best_y); end
        $display("test_reset_mid: rerun best=%0d at (%0d,%0d)", best_sad, best_x, best_y);
    endtask

    task automatic test_early_term();
        bit to; int p, d, b, o, s; int exp_p;
`ifdef SAD_SCHED_EARLY_TERM_EN
        exp_p = 2;
`else
        exp_p = NCAND;
`endif
        mode = 2; resp_delay = 1; stray_en = 1'b0;
        run_search(1'b0, to, p, d, b, o, s);
        checks++; if (to) begin failures++; $display("FAIL early_timeout got=timeout want=done"); end
        checks++; if (p != exp_p) begin failures++; $display("FAIL early_pulses got=%0d want=%0d", p, exp_p); end
        checks++; if (best_sad !== 32'd0 || best_x !== 2'd1 || best_y !== 2'd0) begin failures++;
            $display("FAIL early_best got=%0d@(%0d,%0d) want=0@(1,0)", best_sad, best_x, best_y); end
        $display("test_early_term: pulses=%0d best=%0d", p, best_sad);
    endtask

    task automatic test_all_max();
        bit to; int p, d, b, o, s;
        mode = 3; resp_delay = 1; stray_en = 1'b0;
        run_search(1'b0, to, p, d, b, o, s);
        checks++; if (to || p != NCAND) begin failures++; $display("FAIL allmax_run got to=%0b pulses=%0d want 0 16", to, p); end
        checks++; if (best_sad !== SAD_MAX || best_x !== 2'd0 || best_y !== 2'd0) begin failures++;
            $display("FAIL allmax_best got=%h@(%0d,%0d) want=%h@(0,0)", best_sad, best_x, best_y, SAD_MAX); end
        $display("test_all_max: best=%h at (%0d,%0d)", best_sad, best_x, best_y);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_protocol();
        test_reset_mid();
        test_early_term();
        test_all_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
